usb_rx_controller: RTL and testbench

Receive-side sequencer for the USB transceiver. It decodes the full-speed line state (NRZI), detects SYNC, removes stuffed bits and detects EOP. It drives the receive shift/hold register with select, serial data and per-bit shift enable, and reports byte boundaries, packet completion and line errors to the packet layer. It sits between the line receiver (already bit-synchronised, one sample per bit) and the shift/hold register.

---
 rtl/usb_rx_controller_if.sv | 28 ++
 rtl/usb_rx_controller.sv | 197 +++++++++++++++++++
 tb/tb_usb_rx_controller.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_controller_if.sv
// rtl/usb_rx_controller_if.sv - line-receiver and shift/hold-register signals for usb_rx_controller
interface usb_rx_controller_if;
  logic       rx_en;
  logic       rx_dp;
  logic       rx_dm;
  logic       shift_sel;
  logic       shift_din;
  logic       shift_en;
  logic       byte_valid;
  logic [7:0] rx_data;
  logic [6:0] byte_cnt;
  logic       rx_active;
  logic       pkt_done;
  logic       rx_error;
  logic [2:0] err_code;

  modport master (
    input  rx_en, rx_dp, rx_dm,
    output shift_sel, shift_din, shift_en, byte_valid, rx_data, byte_cnt,
           rx_active, pkt_done, rx_error, err_code
  );

  modport slave (
    output rx_en, rx_dp, rx_dm,
    input  shift_sel, shift_din, shift_en, byte_valid, rx_data, byte_cnt,
           rx_active, pkt_done, rx_error, err_code
  );
endinterface

// File: rtl/usb_rx_controller.sv
// rtl/usb_rx_controller.sv - USB full-speed receive sequencer: NRZI decode, SYNC, unstuffing, EOP
// Optional first-byte PID check enabled by defining USB_RX_PID_CHECK_EN.
module usb_rx_controller #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int IDLE_BITS      = 7,
  parameter int MAX_BYTES      = 64
) (
  input logic clk,
  input logic rst_n,
  usb_rx_controller_if.master bus
);
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_SE1 = 2'b11;
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [2:0]    SYNC_MIN  = 3'(SYNC_MIN_ZEROS);
  localparam logic [6:0]    BYTE_MAX  = 7'(MAX_BYTES);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP1, S_EOP2, S_ERROR} state_t;

  state_t        state, state_n;
  logic [1:0]    prev_line, prev_n;
  logic [2:0]    zero_cnt, zero_n, ones_cnt, ones_n, bit_cnt, bit_n;
  logic [2:0]    err_code, err_code_n, err_val;
  logic [7:0]    shadow, shadow_n, rx_data, rx_data_n;
  logic [6:0]    byte_cnt, byte_cnt_n, byte_inc;
  logic [IW-1:0] idle_cnt, idle_n;
  logic          shift_sel, shift_sel_n, shift_din, shift_din_n, shift_en, shift_en_n;
  logic          byte_valid, byte_valid_n, rx_active, rx_active_n;
  logic          pkt_done, pkt_done_n, rx_error, rx_error_n;
  logic          pid_pend, pid_pend_n, err_hit;
  logic [1:0]    line;
  logic          is_jk, dbit;

  assign line     = {bus.rx_dp, bus.rx_dm};
  assign is_jk    = bus.rx_dp ^ bus.rx_dm;
  assign dbit     = (line == prev_line);
  assign byte_inc = byte_cnt + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;      prev_line <= LINE_J;
      zero_cnt <= '0;       ones_cnt <= '0;     bit_cnt <= '0;
      idle_cnt <= '0;       shadow <= '0;       pid_pend <= 1'b0;
      shift_sel <= 1'b0;    shift_din <= 1'b0;  shift_en <= 1'b0;
      byte_valid <= 1'b0;   rx_data <= '0;      byte_cnt <= '0;
      rx_active <= 1'b0;    pkt_done <= 1'b0;   rx_error <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_n;       prev_line <= prev_n;
      zero_cnt <= zero_n;     ones_cnt <= ones_n;       bit_cnt <= bit_n;
      idle_cnt <= idle_n;     shadow <= shadow_n;       pid_pend <= pid_pend_n;
      shift_sel <= shift_sel_n;   shift_din <= shift_din_n; shift_en <= shift_en_n;
      byte_valid <= byte_valid_n; rx_data <= rx_data_n;     byte_cnt <= byte_cnt_n;
      rx_active <= rx_active_n;   pkt_done <= pkt_done_n;   rx_error <= rx_error_n;
      err_code <= err_code_n;
    end
  end

  always_comb begin
    state_n = state;        prev_n = prev_line;
    zero_n = zero_cnt;      ones_n = ones_cnt;        bit_n = bit_cnt;
    idle_n = idle_cnt;      shadow_n = shadow;        pid_pend_n = 1'b0;
    shift_sel_n = shift_sel; shift_din_n = shift_din; shift_en_n = 1'b0;
    byte_valid_n = 1'b0;    rx_data_n = rx_data;      byte_cnt_n = byte_cnt;
    rx_active_n = rx_active; pkt_done_n = 1'b0;       rx_error_n = 1'b0;
    err_code_n = err_code;  err_hit = 1'b0;           err_val = 3'd0;

    if (is_jk) prev_n = line;

    if (!bus.rx_en) begin
      state_n = S_IDLE;
      prev_n = LINE_J;
      shift_sel_n = 1'b0;
      rx_active_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (line == LINE_K) begin
            state_n = S_SYNC;
            zero_n = 3'd1;
          end
        end
        S_SYNC: begin
          if (line == LINE_SE1) begin
            err_hit = 1'b1; err_val = 3'd2;
          end else if (line == LINE_SE0) begin
            state_n = S_IDLE;
          end else if (!dbit) begin
            zero_n = (zero_cnt == 3'd7) ? 3'd7 : zero_cnt + 3'd1;
          end else if (zero_cnt >= SYNC_MIN) begin
            state_n = S_DATA;
            shift_sel_n = 1'b1; rx_active_n = 1'b1;
            ones_n = 3'd1; bit_n = 3'd0; byte_cnt_n = 7'd0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_DATA: begin
          // A pending PID mismatch wins over whatever the line does this cycle.
          if (pid_pend) begin
            err_hit = 1'b1; err_val = 3'd5;
          end else if (line == LINE_SE1) begin
            err_hit = 1'b1; err_val = 3'd2;
          end else if (line == LINE_SE0) begin
            if (bit_cnt != 3'd0) begin
              err_hit = 1'b1; err_val = 3'd3;
            end else begin
              state_n = S_EOP1;
            end
          end else if (ones_cnt == 3'd6) begin
            if (dbit) begin
              err_hit = 1'b1; err_val = 3'd1;
            end else begin
              ones_n = 3'd0;
            end
          end else begin
            shift_en_n = 1'b1;
            shift_din_n = dbit;
            shadow_n[bit_cnt] = dbit;
            ones_n = dbit ? ones_cnt + 3'd1 : 3'd0;
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_inc > BYTE_MAX) begin
                err_hit = 1'b1; err_val = 3'd4;
              end else begin
                byte_valid_n = 1'b1;
                rx_data_n = shadow_n;
                byte_cnt_n = byte_inc;
`ifdef USB_RX_PID_CHECK_EN
                if (byte_cnt == 7'd0 && shadow_n[7:4] != ~shadow_n[3:0]) pid_pend_n = 1'b1;
`endif
              end
            end
          end
        end
        S_EOP1: begin
          if (line == LINE_SE1) begin
            err_hit = 1'b1; err_val = 3'd2;
          end else if (line == LINE_SE0) begin
            state_n = S_EOP2;
          end else begin
            err_hit = 1'b1; err_val = 3'd6;
          end
        end
        S_EOP2: begin
          if (line == LINE_SE1) begin
            err_hit = 1'b1; err_val = 3'd2;
          end else if (line == LINE_J) begin
            pkt_done_n = 1'b1;
            shift_sel_n = 1'b0; rx_active_n = 1'b0;
            state_n = S_IDLE;
          end else begin
            err_hit = 1'b1; err_val = 3'd6;
          end
        end
        S_ERROR: begin
          if (line == LINE_J) begin
            if (idle_cnt == IDLE_LAST) begin
              idle_n = '0;
              state_n = S_IDLE;
            end else begin
              idle_n = idle_cnt + 1'b1;
            end
          end else begin
            idle_n = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (err_hit) begin
      rx_error_n = 1'b1;
      err_code_n = err_val;
      shift_sel_n = 1'b0;
      rx_active_n = 1'b0;
      byte_valid_n = 1'b0;
      pid_pend_n = 1'b0;
      idle_n = '0;
      state_n = S_ERROR;
    end
  end

  assign bus.shift_sel  = shift_sel;
  assign bus.shift_din  = shift_din;
  assign bus.shift_en   = shift_en;
  assign bus.byte_valid = byte_valid;
  assign bus.rx_data    = rx_data;
  assign bus.byte_cnt   = byte_cnt;
  assign bus.rx_active  = rx_active;
  assign bus.pkt_done   = pkt_done;
  assign bus.rx_error   = rx_error;
  assign bus.err_code   = err_code;
endmodule

// File: tb/tb_usb_rx_controller.sv
// tb/tb_usb_rx_controller.sv - scoreboard bench for usb_rx_controller with randomized packets
module tb_usb_rx_controller;
  localparam int SYNC_MIN_ZEROS = 5;
  localparam int IDLE_BITS      = 7;
  localparam int MAX_BYTES      = 64;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;
  localparam int EV_BYTE = 0, EV_DONE = 1, EV_ERR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_rx_controller_if bus();

  usb_rx_controller #(
    .SYNC_MIN_ZEROS(SYNC_MIN_ZEROS),
    .IDLE_BITS(IDLE_BITS),
    .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cnt;
    int         code;
    int         shifts;
    bit         chk_cnt;
  } ev_t;

  ev_t        expq[$];
  int         tests = 0;
  int         fails = 0;
  logic [1:0] cur;
  int         run;
  logic [7:0] pkt[70];
  int         pn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pidfix(input logic [7:0] v);
`ifdef USB_RX_PID_CHECK_EN
    return {~v[3:0], v[3:0]};
`else
    return v;
`endif
  endfunction

  function automatic ev_t mk(input int kind, input logic [7:0] d, input int cnt,
                             input int code, input int shifts, input bit chk);
    ev_t e;
    e.kind = kind; e.data = d; e.cnt = cnt; e.code = code; e.shifts = shifts; e.chk_cnt = chk;
    return e;
  endfunction

  // ---------------- line drivers (NRZI encoder + bit stuffer) ----------------
  task automatic sym(input logic [1:0] s);
    @(posedge clk); #1;
    bus.rx_dp = s[1];
    bus.rx_dm = s[0];
  endtask

  task automatic nrzi(input bit b);
    if (!b) cur = (cur == J) ? K : J;
    sym(cur);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) nrzi(1'b0);
    nrzi(1'b1);
    run = 1;
  endtask

  task automatic dbit(input bit b);
    nrzi(b);
    if (b) begin
      run++;
      if (run == 6) begin
        nrzi(1'b0);
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic dbyte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) dbit(v[i]);
  endtask

  task automatic eop();
    sym(SE0); sym(SE0); sym(J);
    cur = J;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sym(J);
    cur = J;
  endtask

  // ---------------- packet scenarios with expected responses ----------------
  task automatic pkt_clean();
    send_sync();
    for (int i = 0; i < pn; i++) begin
      expq.push_back(mk(EV_BYTE, pkt[i], i + 1, 0, 0, 1'b0));
`ifdef USB_RX_PID_CHECK_EN
      if (i == 0 && (pkt[0][7:4] ^ pkt[0][3:0]) != 4'hF) begin
        expq.push_back(mk(EV_ERR, 8'h00, 1, 5, 8, 1'b1));
        dbyte(pkt[0]);
        idle(IDLE_BITS + 3);
        return;
      end
`endif
      dbyte(pkt[i]);
    end
    expq.push_back(mk(EV_DONE, 8'h00, pn, 0, 8 * pn, 1'b1));
    eop();
    idle($urandom_range(1, 4));
  endtask

  task automatic pkt_err(input int n, input int k, input int code);
    send_sync();
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = $urandom_range(0, 255);
      if (i == 0) v = pidfix(v);
      expq.push_back(mk(EV_BYTE, v, i + 1, 0, 0, 1'b0));
      dbyte(v);
    end
    for (int j = 0; j < k; j++) dbit(1'($urandom_range(0, 1)));
    expq.push_back(mk(EV_ERR, 8'h00, n, code, 8 * n + k, 1'b1));
    case (code)
      2:       sym(SE1);
      3:       sym(SE0);
      default: begin sym(SE0); sym(J); end
    endcase
    idle(IDLE_BITS + 2);
  endtask

  task automatic err_stuff();
    send_sync();
    expq.push_back(mk(EV_ERR, 8'h00, 0, 1, 5, 1'b1));
    for (int i = 0; i < 6; i++) nrzi(1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_shift_sel"},  bus.shift_sel, 0);
    check({tag, "_shift_din"},  bus.shift_din, 0);
    check({tag, "_shift_en"},   bus.shift_en, 0);
    check({tag, "_byte_valid"}, bus.byte_valid, 0);
    check({tag, "_rx_data"},    bus.rx_data, 0);
    check({tag, "_byte_cnt"},   bus.byte_cnt, 0);
    check({tag, "_rx_active"},  bus.rx_active, 0);
    check({tag, "_pkt_done"},   bus.pkt_done, 0);
    check({tag, "_rx_error"},   bus.rx_error, 0);
    check({tag, "_err_code"},   bus.err_code, 0);
  endtask

  // ---------------- monitor ----------------
  int  mon_shifts = 0;
  bit  mon_last_act = 1'b0;
  ev_t mon_e;

  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e = mk(0, 8'h00, 0, 0, 0, 1'b0);
    if (expq.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      e = expq.pop_front();
      check("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  always @(negedge clk) begin
    bit ok;
    if (bus.rx_active && !mon_last_act) mon_shifts = 0;
    mon_last_act = bus.rx_active;
    if (bus.shift_en) mon_shifts++;
    if (bus.byte_valid) begin
      take(EV_BYTE, mon_e, ok);
      if (ok) begin
        check("rx_data", bus.rx_data, mon_e.data);
        check("byte_cnt", bus.byte_cnt, mon_e.cnt);
      end
    end
    if (bus.pkt_done) begin
      take(EV_DONE, mon_e, ok);
      if (ok) begin
        check("done_shift_count", mon_shifts, mon_e.shifts);
        check("done_byte_cnt", bus.byte_cnt, mon_e.cnt);
        check("done_shift_sel", bus.shift_sel, 0);
      end
    end
    if (bus.rx_error) begin
      take(EV_ERR, mon_e, ok);
      if (ok) begin
        check("err_code", bus.err_code, mon_e.code);
        check("err_shift_count", mon_shifts, mon_e.shifts);
        if (mon_e.chk_cnt) check("err_byte_cnt", bus.byte_cnt, mon_e.cnt);
        check("err_shift_sel", bus.shift_sel, 0);
        check("err_rx_active", bus.rx_active, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.rx_en = 1'b1;
    bus.rx_dp = 1'b1;
    bus.rx_dm = 1'b0;
    cur = J;
    run = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(4);

    pkt[0] = 8'hA5; pn = 1; pkt_clean();
    pkt[0] = 8'hFF; pn = 1; pkt_clean();

    // Exactly IDLE_BITS J cycles must be enough to accept the next packet.
    err_stuff(); idle(IDLE_BITS);
    pkt[0] = 8'hC3; pn = 1; pkt_clean();

    // One J short: the following packet falls inside ERROR and must be ignored.
    err_stuff(); idle(IDLE_BITS - 1);
    send_sync(); dbyte(8'h00); eop();
    idle(IDLE_BITS + 1);

    send_sync();
    expq.push_back(mk(EV_BYTE, 8'h5A, 1, 0, 0, 1'b0));
    dbyte(8'h5A);
    for (int i = 0; i < 4; i++) dbit(1'(i & 1));
    expq.push_back(mk(EV_ERR, 8'h00, 1, 3, 12, 1'b1));
    sym(SE0);
    idle(IDLE_BITS + 2);

    pkt_err(0, 3, 2);
    pkt_err(1, 0, 6);

    // Babble: MAX_BYTES accepted, the next completed byte errors out.
    send_sync();
    for (int i = 0; i <= MAX_BYTES; i++) begin
      logic [7:0] v;
      v = $urandom_range(0, 255);
      if (i == 0) v = pidfix(v);
      if (i < MAX_BYTES) expq.push_back(mk(EV_BYTE, v, i + 1, 0, 0, 1'b0));
      else expq.push_back(mk(EV_ERR, 8'h00, 0, 4, 8 * (MAX_BYTES + 1), 1'b0));
      dbyte(v);
    end
    idle(IDLE_BITS + 2);

    // rx_en drop mid-byte.
    send_sync();
    for (int i = 0; i < 3; i++) dbit(1'b0);
    @(posedge clk); #1;
    bus.rx_en = 1'b0; bus.rx_dp = 1'b1; bus.rx_dm = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rxen_shift_sel", bus.shift_sel, 0);
    check("rxen_rx_active", bus.rx_active, 0);
    @(posedge clk); #1;
    bus.rx_en = 1'b1;
    cur = J;
    idle(3);

    // Reset mid-byte, then a clean packet.
    send_sync();
    for (int i = 0; i < 4; i++) dbit(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.rx_dp = 1'b1; bus.rx_dm = 1'b0;
    @(posedge clk); @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    cur = J;
    idle(3);
    pkt[0] = 8'h3C; pn = 1; pkt_clean();
`ifdef USB_RX_PID_CHECK_EN
    pkt[0] = 8'h96; pkt[1] = 8'h11; pn = 2; pkt_clean();
`endif

    for (int it = 0; it < 30; it++) begin
      int sc;
      sc = $urandom_range(0, 4);
      case (sc)
        0, 1: begin
          pn = $urandom_range(1, 5);
          for (int i = 0; i < pn; i++) pkt[i] = $urandom_range(0, 255);
          if ($urandom_range(0, 3) != 0) pkt[0] = pidfix(pkt[0]);
          pkt_clean();
        end
        2:       pkt_err($urandom_range(0, 3), $urandom_range(1, 7), 3);
        3:       pkt_err($urandom_range(0, 3), $urandom_range(0, 7), 2);
        default: pkt_err($urandom_range(0, 3), 0, 6);
      endcase
    end

    idle(20);
    check("pending_events", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
